// File: rtl/aes_rng_sched_if.sv
// aes_rng_sched_if: seed, RNG and requester signal bundle for the RNG scheduler.
interface aes_rng_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    logic [127:0]       seed_i;
    logic               seed_valid_i;
    logic               seed_ready_o;
    logic [127:0]       rng_seed_o;
    logic               rng_reseed_o;
    logic               rng_enable_o;
    logic               rng_valid_i;
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic               busy_o;
    logic [CNT_W-1:0]   draw_cnt_o;
    logic               err_o;
    modport slave (
        input  seed_i, seed_valid_i, rng_valid_i, req_i,
        output seed_ready_o, rng_seed_o, rng_reseed_o, rng_enable_o, gnt_o, busy_o, draw_cnt_o, err_o
    );
    modport master (
        output seed_i, seed_valid_i, rng_valid_i, req_i,
        input  seed_ready_o, rng_seed_o, rng_reseed_o, rng_enable_o, gnt_o, busy_o, draw_cnt_o, err_o
    );
endinterface

// File: rtl/aes_rng_sched.sv
// aes_rng_sched: round-robin scheduler sharing one masked-AES RNG, with forced periodic reseed.
// Defining RNG_WDOG_EN adds a DRAW timeout that sets a sticky err_o and retries the draw.
module aes_rng_sched #(
    parameter int NUM_REQ         = 4,
    parameter int RESEED_INTERVAL = 1024,
    parameter int CNT_W           = 16,
    parameter int WDOG_CYCLES     = 64
) (
    input  logic           clk,
    input  logic           reset,
    aes_rng_sched_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {SEED_WAIT, IDLE, DRAW, GRANT} state_e;
    state_e             state_q, state_d;
    logic [127:0]       seed_q, seed_d;
    logic               reseed_q, reseed_d, en_q, en_d, err_q, err_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [PW-1:0]      ptr_q, ptr_d, sel_q, sel_d, rr_sel;
`ifdef RNG_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES) + 1;
    logic [WW-1:0]      wdog_q, wdog_d;
`endif
    if (NUM_REQ < 2 || RESEED_INTERVAL < 1 || RESEED_INTERVAL >= 2 ** CNT_W || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("aes_rng_sched: invalid parameter set");
    end
    // Scan downwards so the requester closest to ptr_q wins.
    always_comb begin
        rr_sel = ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (bus.req_i[PW'((int'(ptr_q) + i) % NUM_REQ)]) rr_sel = PW'((int'(ptr_q) + i) % NUM_REQ);
    end
    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        reseed_d = 1'b0;
        en_d     = 1'b0;
        gnt_d    = '0;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        err_d    = err_q;
        cnt_inc  = cnt_q + CNT_W'(1);
`ifdef RNG_WDOG_EN
        wdog_d   = '0;
`endif
        case (state_q)
            SEED_WAIT: if (bus.seed_valid_i) begin
                seed_d   = bus.seed_i;
                reseed_d = 1'b1;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            IDLE: if (|bus.req_i) begin
                sel_d   = rr_sel;
                en_d    = 1'b1;
                state_d = DRAW;
            end
            // en_q marks the first DRAW cycle, whose rng_valid_i belongs to the previous draw.
            DRAW: if (!en_q && bus.rng_valid_i) begin
                gnt_d[sel_q] = 1'b1;
                state_d      = GRANT;
            end
`ifdef RNG_WDOG_EN
            else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else wdog_d = wdog_q + WW'(1);
`endif
            GRANT: begin
                ptr_d   = PW'((int'(sel_q) + 1) % NUM_REQ);
                cnt_d   = cnt_inc;
                state_d = cnt_inc == CNT_W'(RESEED_INTERVAL) ? SEED_WAIT : IDLE;
            end
            default: state_d = SEED_WAIT;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SEED_WAIT;
            seed_q   <= '0;
            reseed_q <= 1'b0;
            en_q     <= 1'b0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            sel_q    <= '0;
            err_q    <= 1'b0;
`ifdef RNG_WDOG_EN
            wdog_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            reseed_q <= reseed_d;
            en_q     <= en_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
`ifdef RNG_WDOG_EN
            wdog_q   <= wdog_d;
`endif
        end
    end
    assign bus.seed_ready_o = state_q == SEED_WAIT;
    assign bus.busy_o       = state_q == DRAW || state_q == GRANT;
    assign bus.rng_seed_o   = seed_q;
    assign bus.rng_reseed_o = reseed_q;
    assign bus.rng_enable_o = en_q;
    assign bus.gnt_o        = gnt_q;
    assign bus.draw_cnt_o   = cnt_q;
    assign bus.err_o        = err_q;
endmodule
